pslip_grant_arb: RTL
====================

# pslip_grant_arb

Output-side grant arbiter for the pSLIP scheduler, one instance per output port. It snapshots the per-input priority requests for a slot and grants one requester per iteration. The winner is drawn from the highest-priority class, with round-robin among ties. The arbiter then waits for the input's accept/reject handshake, iterating on rejects. It is the responding end of the request path whose inputs are P-level priority codes, where code 0 means no request.

## Interface
- N, 32, number of input ports
- P, 16, number of priority levels; code width is $clog2(P); code 0 = no request
- ITER, 4, maximum grant iterations per slot (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a slot; sampled only in IDLE
- req_pri  in  [$clog2(P)-1:0] x [0:N-1]  per-input request priority, captured on start
- acc_valid  in  1  accept response present for current grant
- acc  in  1  1 = granted input accepts, 0 = rejects
- grant  out  N  one-hot grant vector
- grant_idx  out  $clog2(N)  index of granted input
- grant_pri  out  $clog2(P)  priority of granted request
- grant_valid  out  1  grant outstanding, awaiting response
- done  out  1  one-cycle slot-complete pulse
- matched  out  1  slot result: 1 = a grant was accepted; valid with done and held afterwards
- ptr  out  $clog2(N)  current round-robin pointer (observability)

## Operation
- States: IDLE, ARB, WAIT, DONE.
- IDLE: on start=1, register req_pri into snapshot, clear elig_mask to all-ones, set iter=1, go to ARB. Otherwise stay.
- ARB: eligible = snapshot≠0 AND elig_mask.
  - If none are eligible: matched<=0, go to DONE.
  - Otherwise, max = largest eligible code and cand = eligible inputs with code==max.
  - Winner = first cand index at or after ptr, ascending, wrapping N-1→0.
  - Register grant/grant_idx/grant_pri and go to WAIT.
- WAIT: grant_valid=1. Hold until acc_valid=1.
  - acc=1: matched<=1. If iter==1, ptr<=(grant_idx+1) mod N, per the iSLIP first-iteration-only update. Go to DONE.
  - acc=0: clear elig_mask[grant_idx]. If iter==ITER: matched<=0, go to DONE. Else iter<=iter+1, go to ARB.
- DONE: done=1 for this cycle, then go to IDLE.
- The ptr changes only on a first-iteration accept. It never changes on a reject or on an empty slot.
- start outside IDLE is ignored. req_pri changes after capture have no effect.
- acc_valid outside WAIT is ignored.
- Width rules: pointer wrap is mod N, and N need not be a power of two. grant_pri equals the snapshot code exactly.

## Timing
- Reset (async, rst_n=0): state=IDLE, grant=0, grant_idx=0, grant_pri=0, grant_valid=0, done=0, matched=0, ptr=0, iter=1, elig_mask=all-ones, snapshot=0.
- Reset assertion mid-slot aborts immediately to the reset values. No done pulse is produced.
- Latency:
  - start (cycle 0) → ARB (cycle 1) → grant_valid high from cycle 2.
  - Accept sampled in cycle k → done in cycle k+1 → IDLE in k+2. The earliest next start is accepted in k+2.
  - Empty slot: start (0) → ARB (1) → done (2).
- Each reject adds 2 cycles (WAIT→ARB→WAIT). grant_valid is low during ARB.
- grant, grant_idx and grant_pri hold their values through DONE and IDLE until the next ARB overwrites them. On an empty ARB they are cleared to 0.
- matched holds its value until the next ARB decision.

## Test plan
- Reset/idle: apply rst_n=0 mid-WAIT → all outputs at reset values in the same cycle; after release, ptr=0 and no done pulse.
- Priority select: ptr=0, req_pri[3]=5, req_pri[9]=12, req_pri[20]=12, all others 0; start; acc=1 at first grant → grant_idx=9, grant_pri=12, matched=1, ptr=10, done 1 cycle after the accept.
- Round-robin tie: ptr=10 with the same requests; start, accept → grant_idx=20, ptr=21. Repeat the slot → grant_idx=9 (wraps past 31), ptr=10.
- Reject iteration: requests [9]=12, [20]=12, [3]=5, ptr=10.
  - Reject 20, then reject 9 → third grant is idx 3, pri 5.
  - Accept → matched=1 and ptr unchanged at 10, because the accept was not on iteration 1.
- Iteration limit: ITER=2, three requests all rejected → exactly 2 grants, matched=0, done pulse, ptr unchanged.
- Empty/ignored inputs: all req_pri=0 → done at cycle 2 with matched=0 and grant=0. start asserted during WAIT and acc_valid asserted in IDLE both cause no state change.

Source files
------------

// File: rtl/pslip_grant_arb.sv
`default_nettype none
// ============================================================================
// Module   : pslip_grant_arb
// Purpose  : pSLIP output-side grant arbiter; highest priority class wins,
//            round-robin among ties, iterates on rejects up to ITER times.
// Revision : 1.0  initial release
// ============================================================================
module pslip_grant_arb #(
    parameter int N    = 32,
    parameter int P    = 16,
    parameter int ITER = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [$clog2(P)-1:0] req_pri [N],
    input  logic                 acc_valid,
    input  logic                 acc,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [$clog2(P)-1:0] grant_pri,
    output logic                 grant_valid,
    output logic                 done,
    output logic                 matched,
    output logic [$clog2(N)-1:0] ptr
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(P);
    localparam int TW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PW-1:0]  r_snap [N];
    logic [N-1:0]   r_elig;
    logic [TW-1:0]  r_iter;
    logic [N-1:0]   r_grant;
    logic [IW-1:0]  r_grant_idx;
    logic [PW-1:0]  r_grant_pri;
    logic           r_matched;
    logic [IW-1:0]  r_ptr;

    logic [N-1:0]   w_eligible;
    logic           w_any;
    logic [PW-1:0]  w_max;
    logic [IW-1:0]  w_win;
    logic           w_found;

    // Winner search: top eligible class, then first candidate at/after ptr with wrap.
    always_comb begin
        int j;
        j          = 0;
        w_eligible = '0;
        w_max      = '0;
        w_win      = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_eligible[i] = (r_snap[i] != '0) && r_elig[i];
            if (w_eligible[i] && (r_snap[i] > w_max))
                w_max = r_snap[i];
        end
        w_any = |w_eligible;
        for (int k = 0; k < N; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N)
                j = j - N;
            if (!w_found && w_eligible[j] && (r_snap[j] == w_max)) begin
                w_found = 1'b1;
                w_win   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        grant_valid = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_ARB;
            S_ARB:  w_next = w_any ? S_WAIT : S_DONE;
            S_WAIT: begin
                grant_valid = 1'b1;
                if (acc_valid) begin
                    if (acc || (r_iter == TW'(ITER)))
                        w_next = S_DONE;
                    else
                        w_next = S_ARB;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elig      <= '1;
            r_iter      <= TW'(1);
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_grant_pri <= '0;
            r_matched   <= 1'b0;
            r_ptr       <= '0;
            for (int i = 0; i < N; i++)
                r_snap[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++)
                            r_snap[i] <= req_pri[i];
                        r_elig <= '1;
                        r_iter <= TW'(1);
                    end
                end
                S_ARB: begin
                    if (!w_any) begin
                        r_matched   <= 1'b0;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        r_grant_pri <= '0;
                    end else begin
                        r_grant     <= {{(N-1){1'b0}}, 1'b1} << w_win;
                        r_grant_idx <= w_win;
                        r_grant_pri <= w_max;
                    end
                end
                S_WAIT: begin
                    if (acc_valid) begin
                        if (acc) begin
                            r_matched <= 1'b1;
                            // Pointer only advances on a first-iteration accept.
                            if (r_iter == TW'(1))
                                r_ptr <= (r_grant_idx == IW'(N - 1)) ? '0 : r_grant_idx + 1'b1;
                        end else begin
                            r_elig[r_grant_idx] <= 1'b0;
                            if (r_iter == TW'(ITER))
                                r_matched <= 1'b0;
                            else
                                r_iter <= r_iter + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign grant_pri = r_grant_pri;
    assign matched   = r_matched;
    assign ptr       = r_ptr;

endmodule
`default_nettype wire
